mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shared main-memory port for the BRISC core: arbitrates 128-bit cache-line requests from the instruction cache (fills only) and the data cache (fills and write-backs), and issues them one at a time to the backing memory array. It models the fixed memory request and response latencies, so it sits directly downstream of both caches and upstream of the memory array. Only one transaction is in flight at a time.

## Interface
Parameters:
- ADDR_W, default ADDRESS_BITS (32): byte-address width.
- LINE_W, default CACHE_LINE_LEN (128): line width in bits.
- REQ_DELAY, default MEM_REQ_DELAY (5): handshake-to-access cycles. Must be ≥2; violation is an elaboration error.
- RESP_DELAY, default MEM_RESP_DELAY (5): access-to-response cycles. Must be ≥2; violation is an elaboration error.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- ic_req_valid_i  in  1  instruction-cache read request.
- ic_req_ready_o  out  1  instruction-cache request accepted this cycle.
- ic_req_addr_i  in  ADDR_W  instruction-cache byte address.
- ic_resp_valid_o  out  1  one-cycle pulse; fill data valid.
- ic_resp_data_o  out  LINE_W  fill line.
- dc_req_valid_i  in  1  data-cache request.
- dc_req_ready_o  out  1  data-cache request accepted this cycle.
- dc_req_write_i  in  1  1 = write-back, 0 = fill.
- dc_req_addr_i  in  ADDR_W  data-cache byte address.
- dc_req_data_i  in  LINE_W  write-back line.
- dc_resp_valid_o  out  1  one-cycle pulse; read or write completed.
- dc_resp_data_o  out  LINE_W  fill line; 0 on write completion.
- mem_req_valid_o  out  1  memory access strobe, one cycle.
- mem_req_write_o  out  1  write enable.
- mem_req_addr_o  out  ADDR_W  line-aligned address.
- mem_req_data_o  out  LINE_W  write data.
- mem_rdata_i  in  LINE_W  read data; combinational from mem_req_addr_o, sampled in ACCESS.

## Operation
- FSM states: IDLE, REQ_WAIT, ACCESS, RESP_WAIT, DONE.
- In IDLE, requester X's ready_o = X valid AND X wins arbitration. Ready is 0 in every other state.
- Handshake: valid & ready in the same cycle. The request (owner id, write flag, address, data) is latched and the FSM enters REQ_WAIT.
- Arbitration is two-way round-robin. If only one requester is valid, it wins. If both are valid, the one not granted last wins. The last-grant flag resets to "ic", so dc wins the first tie.
- REQ_WAIT lasts REQ_DELAY-1 cycles, then ACCESS.
- ACCESS lasts 1 cycle:
  - mem_req_valid_o=1.
  - mem_req_addr_o = latched address with its low log2(LINE_W/8) bits cleared.
  - mem_req_write_o and mem_req_data_o driven from the latch.
  - For reads, mem_rdata_i is registered into the response register.
- RESP_WAIT lasts RESP_DELAY-1 cycles, then DONE.
- DONE lasts 1 cycle: the owner's resp_valid_o=1 with the response register on its resp_data_o. Next state is IDLE.
- Response outputs carry no ready signal; the caches must accept the pulse.
- The non-owner's resp_valid_o stays 0. All resp_data_o are 0 when not in DONE.
- Requesters must not make valid depend on ready.
- A valid still high in the cycle after the handshake is treated as a new request.

## Timing
- Handshake in cycle T. mem_req_valid_o is high in T+REQ_DELAY. resp_valid_o is high in T+REQ_DELAY+RESP_DELAY. With defaults, the access is at T+5 and the response at T+10.
- Earliest next handshake: T+REQ_DELAY+RESP_DELAY+1 (T+11). Throughput is 1 line per 11 cycles.
- Reset values: state IDLE, last-grant = ic, all latches 0, every registered output 0.
- Ready outputs are combinational from IDLE and the valids, so they are 0 while the valids are low.
- Reset asserted mid-transaction: all registered outputs clear immediately and the transaction is discarded. No response or memory strobe is issued. After release the FSM starts in IDLE.
- No address wrap handling is needed; the address passes through apart from the alignment mask.

## Structure
- Add to the shared package:
  - typedef enum memarb_state_e {IDLE, REQ_WAIT, ACCESS, RESP_WAIT, DONE}.
  - typedef enum requester_e {REQ_IC, REQ_DC}.
  - Constant LINE_OFFSET_BITS = $clog2(CACHE_LINE_LEN/BYTE_LEN).
- One sub-module: delay_counter, a loadable down-counter sized $clog2(max(REQ_DELAY,RESP_DELAY)) with a zero flag. It is reused for both wait states.

## Test plan
- IC read, addr 0x0000_1004, mem_rdata_i=0xAAAA…AAAA → mem_req_addr_o=0x1000, write=0 at T+5; ic_resp_valid_o pulses at T+10 with 0xAAAA…AAAA; dc_resp_valid_o stays 0.
- DC write-back, addr 0x2010, data 0x0123…CDEF → at T+5 mem_req_write_o=1, addr 0x2010, data 0x0123…CDEF; dc_resp_valid_o pulses at T+10 with data 0.
- Both valid in the first cycle after reset → dc granted at T; ic handshake at T+11; ic response at T+21.
- Both valid held continuously for 4 transactions → grant order dc, ic, dc, ic; handshakes at T, T+11, T+22, T+33.
- ic_req_valid_i raised at T+3 during a dc transaction → ic_req_ready_o stays 0 until T+11; handshake then occurs at T+11.
- rst_n pulled low at T+7 of a read → all outputs 0 immediately; no response pulse; a new request after release completes with normal latency.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the main-memory arbiter of the BRISC core.
package mem_arbiter_pkg;

   localparam int ADDRESS_BITS     = 32;
   localparam int CACHE_LINE_LEN   = 128;
   localparam int BYTE_LEN         = 8;
   localparam int MEM_REQ_DELAY    = 5;
   localparam int MEM_RESP_DELAY   = 5;
   localparam int LINE_OFFSET_BITS = $clog2(CACHE_LINE_LEN / BYTE_LEN);

   typedef enum logic [2:0] {
      IDLE,
      REQ_WAIT,
      ACCESS,
      RESP_WAIT,
      DONE
   } memarb_state_e;

   typedef enum logic {
      REQ_IC,
      REQ_DC
   } requester_e;

   // Larger of two integers; used to size the shared wait counter.
   function automatic int maxInt(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the cache request/response buses and the memory array bus.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_arbiter_if import mem_arbiter_pkg::*; #(
   parameter int ADDR_W = ADDRESS_BITS,
   parameter int LINE_W = CACHE_LINE_LEN
);

   logic              ic_req_valid_i;
   logic              ic_req_ready_o;
   logic [ADDR_W-1:0] ic_req_addr_i;
   logic              ic_resp_valid_o;
   logic [LINE_W-1:0] ic_resp_data_o;

   logic              dc_req_valid_i;
   logic              dc_req_ready_o;
   logic              dc_req_write_i;
   logic [ADDR_W-1:0] dc_req_addr_i;
   logic [LINE_W-1:0] dc_req_data_i;
   logic              dc_resp_valid_o;
   logic [LINE_W-1:0] dc_resp_data_o;

   logic              mem_req_valid_o;
   logic              mem_req_write_o;
   logic [ADDR_W-1:0] mem_req_addr_o;
   logic [LINE_W-1:0] mem_req_data_o;
   logic [LINE_W-1:0] mem_rdata_i;

   modport slave (
      input  ic_req_valid_i, ic_req_addr_i,
      input  dc_req_valid_i, dc_req_write_i, dc_req_addr_i, dc_req_data_i,
      input  mem_rdata_i,
      output ic_req_ready_o, ic_resp_valid_o, ic_resp_data_o,
      output dc_req_ready_o, dc_resp_valid_o, dc_resp_data_o,
      output mem_req_valid_o, mem_req_write_o, mem_req_addr_o, mem_req_data_o
   );

   modport master (
      output ic_req_valid_i, ic_req_addr_i,
      output dc_req_valid_i, dc_req_write_i, dc_req_addr_i, dc_req_data_i,
      output mem_rdata_i,
      input  ic_req_ready_o, ic_resp_valid_o, ic_resp_data_o,
      input  dc_req_ready_o, dc_resp_valid_o, dc_resp_data_o,
      input  mem_req_valid_o, mem_req_write_o, mem_req_addr_o, mem_req_data_o
   );

endinterface

// File: rtl/mem_arbiter_delay_counter.sv
// Loadable down-counter with a zero flag; times both memory wait phases.
module delay_counter #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] loadVal_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Load wins over decrement; the count parks at zero instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = loadVal_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the I-cache and D-cache line requests, issuing
// one memory transaction at a time with fixed request/response latencies.
module mem_arbiter import mem_arbiter_pkg::*; #(
   parameter int ADDR_W     = ADDRESS_BITS,
   parameter int LINE_W     = CACHE_LINE_LEN,
   parameter int REQ_DELAY  = MEM_REQ_DELAY,
   parameter int RESP_DELAY = MEM_RESP_DELAY
) (
   input logic          clk,
   input logic          rst_n,
   mem_arbiter_if.slave bus
);

   localparam int OFFSET_BITS = $clog2(LINE_W / BYTE_LEN);
   localparam int CNT_W       = $clog2(maxInt(REQ_DELAY, RESP_DELAY));
   localparam logic [CNT_W-1:0]  REQ_LOAD   = CNT_W'(REQ_DELAY - 2);
   localparam logic [CNT_W-1:0]  RESP_LOAD  = CNT_W'(RESP_DELAY - 2);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((64'd1 << OFFSET_BITS) - 64'd1);

   // The counter reload values assume at least one wait cycle in each phase.
   if (REQ_DELAY < 2) begin : gBadReqDelay
      $error("mem_arbiter: REQ_DELAY must be at least 2");
   end
   if (RESP_DELAY < 2) begin : gBadRespDelay
      $error("mem_arbiter: RESP_DELAY must be at least 2");
   end

   memarb_state_e     state_q;
   requester_e        lastGrant_q;
   requester_e        owner_q;
   logic              write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] data_q;
   logic [LINE_W-1:0] respData_q;
   logic              memReqValid_q;
   logic              memReqWrite_q;
   logic [ADDR_W-1:0] memReqAddr_q;
   logic [LINE_W-1:0] memReqData_q;
   logic              icRespValid_q;
   logic [LINE_W-1:0] icRespData_q;
   logic              dcRespValid_q;
   logic [LINE_W-1:0] dcRespData_q;

   logic             icWins;
   logic             dcWins;
   logic             icReady;
   logic             dcReady;
   logic             cntLoad;
   logic [CNT_W-1:0] cntLoadVal;
   logic             cntDec;
   logic             cntZero;

   // On a tie the requester that was not granted last goes first.
   assign icWins  = bus.ic_req_valid_i && (!bus.dc_req_valid_i || (lastGrant_q == REQ_DC));
   assign dcWins  = bus.dc_req_valid_i && (!bus.ic_req_valid_i || (lastGrant_q == REQ_IC));
   assign icReady = (state_q == IDLE) && icWins;
   assign dcReady = (state_q == IDLE) && dcWins;

   // Reload the wait counter when entering each wait phase, count down inside it.
   always_comb begin
      cntLoad    = 1'b0;
      cntLoadVal = '0;
      cntDec     = 1'b0;
      case (state_q)
         IDLE: begin
            cntLoad    = icReady || dcReady;
            cntLoadVal = REQ_LOAD;
         end
         ACCESS: begin
            cntLoad    = 1'b1;
            cntLoadVal = RESP_LOAD;
         end
         REQ_WAIT, RESP_WAIT: cntDec = 1'b1;
         default: cntDec = 1'b0;
      endcase
   end

   delay_counter #(.CNT_W(CNT_W)) uDelayCounter (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (cntLoad),
      .loadVal_i (cntLoadVal),
      .dec_i     (cntDec),
      .zero_o    (cntZero)
   );

   // Transaction FSM; strobes and response outputs are registered and last one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         lastGrant_q   <= REQ_IC;
         owner_q       <= REQ_IC;
         write_q       <= 1'b0;
         addr_q        <= '0;
         data_q        <= '0;
         respData_q    <= '0;
         memReqValid_q <= 1'b0;
         memReqWrite_q <= 1'b0;
         memReqAddr_q  <= '0;
         memReqData_q  <= '0;
         icRespValid_q <= 1'b0;
         icRespData_q  <= '0;
         dcRespValid_q <= 1'b0;
         dcRespData_q  <= '0;
      end else begin
         memReqValid_q <= 1'b0;
         memReqWrite_q <= 1'b0;
         memReqAddr_q  <= '0;
         memReqData_q  <= '0;
         icRespValid_q <= 1'b0;
         icRespData_q  <= '0;
         dcRespValid_q <= 1'b0;
         dcRespData_q  <= '0;
         case (state_q)
            IDLE: begin
               if (dcReady) begin
                  owner_q     <= REQ_DC;
                  lastGrant_q <= REQ_DC;
                  write_q     <= bus.dc_req_write_i;
                  addr_q      <= bus.dc_req_addr_i;
                  data_q      <= bus.dc_req_data_i;
                  state_q     <= REQ_WAIT;
               end else if (icReady) begin
                  owner_q     <= REQ_IC;
                  lastGrant_q <= REQ_IC;
                  write_q     <= 1'b0;
                  addr_q      <= bus.ic_req_addr_i;
                  data_q      <= '0;
                  state_q     <= REQ_WAIT;
               end
            end
            REQ_WAIT: begin
               if (cntZero) begin
                  memReqValid_q <= 1'b1;
                  memReqWrite_q <= write_q;
                  memReqAddr_q  <= addr_q & ALIGN_MASK;
                  memReqData_q  <= data_q;
                  state_q       <= ACCESS;
               end
            end
            ACCESS: begin
               respData_q <= write_q ? '0 : bus.mem_rdata_i;
               state_q    <= RESP_WAIT;
            end
            RESP_WAIT: begin
               if (cntZero) begin
                  if (owner_q == REQ_IC) begin
                     icRespValid_q <= 1'b1;
                     icRespData_q  <= respData_q;
                  end else begin
                     dcRespValid_q <= 1'b1;
                     dcRespData_q  <= respData_q;
                  end
                  state_q <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.ic_req_ready_o  = icReady;
   assign bus.dc_req_ready_o  = dcReady;
   assign bus.ic_resp_valid_o = icRespValid_q;
   assign bus.ic_resp_data_o  = icRespData_q;
   assign bus.dc_resp_valid_o = dcRespValid_q;
   assign bus.dc_resp_data_o  = dcRespData_q;
   assign bus.mem_req_valid_o = memReqValid_q;
   assign bus.mem_req_write_o = memReqWrite_q;
   assign bus.mem_req_addr_o  = memReqAddr_q;
   assign bus.mem_req_data_o  = memReqData_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single reads/writes, round-robin ties,
// late requests during a transaction and reset in the middle of a read.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int ADDR_W  = 32;
   localparam int LINE_W  = 128;
   localparam int REQ_D   = 5;
   localparam int RESP_D  = 5;
   localparam int RESP_AT = REQ_D + RESP_D;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int testsRun    = 0;
   int testsFailed = 0;

   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

   mem_arbiter #(
      .ADDR_W     (ADDR_W),
      .LINE_W     (LINE_W),
      .REQ_DELAY  (REQ_D),
      .RESP_DELAY (RESP_D)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Count one comparison and report it when the observed value is wrong.
   task automatic checkOutput(input string tag, input logic [LINE_W-1:0] observed,
                              input logic [LINE_W-1:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   // Drive the cache request inputs.
   task automatic applyStimulus(input logic icValid, input logic [ADDR_W-1:0] icAddr,
                                input logic dcValid, input logic dcWrite,
                                input logic [ADDR_W-1:0] dcAddr, input logic [LINE_W-1:0] dcData);
      bus.ic_req_valid_i = icValid;
      bus.ic_req_addr_i  = icAddr;
      bus.dc_req_valid_i = dcValid;
      bus.dc_req_write_i = dcWrite;
      bus.dc_req_addr_i  = dcAddr;
      bus.dc_req_data_i  = dcData;
   endtask

   // Advance to just after the next rising edge.
   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Check both readies in the current cycle.
   task automatic checkReady(input string tag, input logic expIc, input logic expDc);
      checkOutput({tag, "/icReady"}, LINE_W'(bus.ic_req_ready_o), LINE_W'(expIc));
      checkOutput({tag, "/dcReady"}, LINE_W'(bus.dc_req_ready_o), LINE_W'(expDc));
   endtask

   // Called in the handshake cycle T; follows the transaction through T+RESP_AT.
   task automatic watchTransaction(input string tag, input logic ownerDc, input logic isWrite,
                                   input logic [ADDR_W-1:0] expAddr, input logic [LINE_W-1:0] expWData,
                                   input logic [LINE_W-1:0] rdataDrive, input logic [LINE_W-1:0] expRData,
                                   input logic holdValids, input int raiseIcAt);
      bus.mem_rdata_i = rdataDrive;
      for (int k = 1; k <= RESP_AT; k++) begin
         stepCycle();
         if (k == 1 && !holdValids) begin
            bus.ic_req_valid_i = 1'b0;
            bus.dc_req_valid_i = 1'b0;
         end
         if (k == raiseIcAt) bus.ic_req_valid_i = 1'b1;
         #1;
         checkOutput($sformatf("%s/memValid@T+%0d", tag, k), LINE_W'(bus.mem_req_valid_o), LINE_W'(k == REQ_D));
         checkOutput($sformatf("%s/icRespValid@T+%0d", tag, k), LINE_W'(bus.ic_resp_valid_o),
                     LINE_W'(k == RESP_AT && !ownerDc));
         checkOutput($sformatf("%s/dcRespValid@T+%0d", tag, k), LINE_W'(bus.dc_resp_valid_o),
                     LINE_W'(k == RESP_AT && ownerDc));
         checkOutput($sformatf("%s/icRespData@T+%0d", tag, k), bus.ic_resp_data_o,
                     (k == RESP_AT && !ownerDc) ? expRData : '0);
         checkOutput($sformatf("%s/dcRespData@T+%0d", tag, k), bus.dc_resp_data_o,
                     (k == RESP_AT && ownerDc) ? expRData : '0);
         checkReady($sformatf("%s@T+%0d", tag, k), 1'b0, 1'b0);
         if (k == REQ_D) begin
            checkOutput({tag, "/memWrite"}, LINE_W'(bus.mem_req_write_o), LINE_W'(isWrite));
            checkOutput({tag, "/memAddr"}, LINE_W'(bus.mem_req_addr_o), LINE_W'(expAddr));
            if (isWrite) checkOutput({tag, "/memData"}, bus.mem_req_data_o, expWData);
         end
      end
   endtask

   localparam logic [LINE_W-1:0] PAT_A    = 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA;
   localparam logic [LINE_W-1:0] PAT_WB   = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [LINE_W-1:0] PAT_R1   = 128'h11112222333344445555666677778888;
   localparam logic [LINE_W-1:0] PAT_R2   = 128'h9999AAAABBBBCCCCDDDDEEEEFFFF0000;
   localparam logic [LINE_W-1:0] PAT_JUNK = 128'h5555555555555555555555555555555A;

   initial begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      bus.mem_rdata_i = '0;

      // Reset state.
      stepCycle();
      stepCycle();
      checkOutput("reset/memValid", LINE_W'(bus.mem_req_valid_o), '0);
      checkOutput("reset/memWrite", LINE_W'(bus.mem_req_write_o), '0);
      checkOutput("reset/memAddr", LINE_W'(bus.mem_req_addr_o), '0);
      checkOutput("reset/memData", bus.mem_req_data_o, '0);
      checkOutput("reset/icRespValid", LINE_W'(bus.ic_resp_valid_o), '0);
      checkOutput("reset/dcRespValid", LINE_W'(bus.dc_resp_valid_o), '0);
      checkReady("reset", 1'b0, 1'b0);
      rst_n = 1'b1;
      stepCycle();

      // Both held valid from the first cycle after reset: dc, ic, dc, ic.
      applyStimulus(1'b1, 32'h0000_4020, 1'b1, 1'b0, 32'h0000_3008, '0);
      #1;
      checkReady("tie0", 1'b0, 1'b1);
      watchTransaction("tie0", 1'b1, 1'b0, 32'h0000_3000, '0, PAT_R1, PAT_R1, 1'b1, -1);
      stepCycle();
      checkReady("tie1", 1'b1, 1'b0);
      watchTransaction("tie1", 1'b0, 1'b0, 32'h0000_4020, '0, PAT_R2, PAT_R2, 1'b1, -1);
      stepCycle();
      checkReady("tie2", 1'b0, 1'b1);
      watchTransaction("tie2", 1'b1, 1'b0, 32'h0000_3000, '0, PAT_A, PAT_A, 1'b1, -1);
      stepCycle();
      checkReady("tie3", 1'b1, 1'b0);
      watchTransaction("tie3", 1'b0, 1'b0, 32'h0000_4020, '0, PAT_R1, PAT_R1, 1'b0, -1);

      // Single I-cache read with an unaligned address.
      stepCycle();
      applyStimulus(1'b1, 32'h0000_1004, 1'b0, 1'b0, '0, '0);
      #1;
      checkReady("icRead", 1'b1, 1'b0);
      watchTransaction("icRead", 1'b0, 1'b0, 32'h0000_1000, '0, PAT_A, PAT_A, 1'b0, -1);

      // D-cache write-back completes with zero data.
      stepCycle();
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h0000_2010, PAT_WB);
      #1;
      checkReady("dcWrite", 1'b0, 1'b1);
      watchTransaction("dcWrite", 1'b1, 1'b1, 32'h0000_2010, PAT_WB, PAT_JUNK, '0, 1'b0, -1);

      // I-cache request raised at T+3 of a D-cache read waits until T+11.
      stepCycle();
      applyStimulus(1'b0, 32'h0000_6044, 1'b1, 1'b0, 32'h0000_5000, '0);
      #1;
      checkReady("late", 1'b0, 1'b1);
      watchTransaction("late", 1'b1, 1'b0, 32'h0000_5000, '0, PAT_R2, PAT_R2, 1'b0, 3);
      stepCycle();
      checkReady("lateIc", 1'b1, 1'b0);
      watchTransaction("lateIc", 1'b0, 1'b0, 32'h0000_6040, '0, PAT_R1, PAT_R1, 1'b0, -1);

      // Reset at T+7 of an I-cache read discards it.
      stepCycle();
      applyStimulus(1'b1, 32'h0000_7000, 1'b0, 1'b0, '0, '0);
      bus.mem_rdata_i = PAT_A;
      #1;
      checkReady("rstRead", 1'b1, 1'b0);
      for (int k = 1; k <= 6; k++) begin
         stepCycle();
         if (k == 1) bus.ic_req_valid_i = 1'b0;
         #1;
         if (k == REQ_D) checkOutput("rstRead/memValid@T+5", LINE_W'(bus.mem_req_valid_o), LINE_W'(1'b1));
      end
      stepCycle();
      rst_n = 1'b0;
      #1;
      checkOutput("midReset/memValid", LINE_W'(bus.mem_req_valid_o), '0);
      checkOutput("midReset/memAddr", LINE_W'(bus.mem_req_addr_o), '0);
      checkOutput("midReset/icRespValid", LINE_W'(bus.ic_resp_valid_o), '0);
      checkOutput("midReset/icRespData", bus.ic_resp_data_o, '0);
      checkOutput("midReset/dcRespValid", LINE_W'(bus.dc_resp_valid_o), '0);
      for (int k = 0; k < 3; k++) begin
         stepCycle();
         checkOutput($sformatf("inReset/icRespValid%0d", k), LINE_W'(bus.ic_resp_valid_o), '0);
         checkOutput($sformatf("inReset/memValid%0d", k), LINE_W'(bus.mem_req_valid_o), '0);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         stepCycle();
         checkOutput($sformatf("postReset/icRespValid%0d", k), LINE_W'(bus.ic_resp_valid_o), '0);
         checkOutput($sformatf("postReset/memValid%0d", k), LINE_W'(bus.mem_req_valid_o), '0);
      end

      // A fresh request after release completes with normal latency.
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0000_804C, '0);
      #1;
      checkReady("afterRst", 1'b0, 1'b1);
      watchTransaction("afterRst", 1'b1, 1'b0, 32'h0000_8040, '0, PAT_R2, PAT_R2, 1'b0, -1);

      stepCycle();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
